// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit BCD up/down counter with programmable wrap limit, validated load and cascade carry
module bcd_counter_ndigit #(
  parameter int DIGITS = 2,
  parameter int W = 4*DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic [W-1:0] limit,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         load_err,
  output logic         carry_out
);
  function automatic logic is_bcd(input logic [W-1:0] v);
    is_bcd = 1'b1;
    for (int i = 0; i < DIGITS; i++) is_bcd = is_bcd & (v[4*i+:4] <= 4'd9);
  endfunction
  logic [W-1:0] eff, inc, dec;
  logic at_top, at_zero, ld_ok, c, b;
  logic [3:0] d;
  assign eff = is_bcd(limit) ? limit : {DIGITS{4'h9}};
  assign at_top = count >= eff;
  assign at_zero = count == '0;
  assign ld_ok = is_bcd(load_val) && load_val <= eff;
  assign carry_out = en & (up_dn ? at_top : at_zero);
  // ripple BCD increment and decrement of the current count
  always_comb begin
    inc = count;
    dec = count;
    c = 1'b1;
    b = 1'b1;
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i+:4];
      inc[4*i+:4] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      dec[4*i+:4] = b ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
      c = c & (d == 4'd9);
      b = b & (d == 4'd0);
    end
  end
  // count register with rst > load > en > hold priority and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (ld_ok) count <= load_val;
        else load_err <= 1'b1;
      end else if (en) begin
        if (up_dn) begin
          count <= at_top ? '0 : inc;
          wrap <= at_top;
        end else begin
          count <= at_zero ? eff : dec;
          wrap <= at_zero;
        end
      end
    end
  end
endmodule
